// File: rtl/shifter_iter.sv
// Iterative shifter/rotator: shifts up to STEP bits per clock until the requested
// amount is consumed, then presents the result for one DONE cycle.
module shifter_iter #(
  parameter int XLEN = 32,
  parameter int STEP = 4,
  localparam int SW = $clog2(XLEN)
) (
  input  logic            i_clk_n,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_in_a,
  input  logic [SW-1:0]   i_in_b,
  input  logic [2:0]      i_funct3,
  input  logic            i_op_alt,
  input  logic            i_rot,
  input  logic            i_shift_en,
  input  logic            i_kill,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy,
  output logic            o_valid
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SW:0] STEP_V = STEP[SW:0];

  state_t          state, state_d;
  logic [XLEN-1:0] res, res_d, res_step;
  logic [SW-1:0]   rem, rem_d;
  logic [SW:0]     k;
  logic            dir_left, dir_left_d;
  logic            rot_m, rot_m_d;
  logic            arith_m, arith_m_d;
  logic            sign, sign_d;
  logic            is_shift, start;

  // One serial bit position; a k-bit step is k of these chained.
  function automatic logic [XLEN-1:0] shift1(input logic [XLEN-1:0] v, input logic left,
                                             input logic rot, input logic arith, input logic sgn);
    logic fill;
    if (left) begin
      fill = rot ? v[XLEN-1] : 1'b0;
      return {v[XLEN-2:0], fill};
    end
    fill = rot ? v[0] : (arith & sgn);
    return {fill, v[XLEN-1:1]};
  endfunction

  assign is_shift = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);
  assign start    = i_shift_en && is_shift && !i_kill && (state != SHIFT);

  always_comb begin
    k        = ({1'b0, rem} < STEP_V) ? {1'b0, rem} : STEP_V;
    res_step = res;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(k)) res_step = shift1(res_step, dir_left, rot_m, arith_m, sign);
    end
  end

  always_comb begin
    state_d    = state;
    res_d      = res;
    rem_d      = rem;
    dir_left_d = dir_left;
    rot_m_d    = rot_m;
    arith_m_d  = arith_m;
    sign_d     = sign;
    if (i_kill) begin
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      case (state)
        SHIFT: begin
          res_d = res_step;
          rem_d = rem - k[SW-1:0];
          if (rem == k[SW-1:0]) state_d = DONE;
        end
        default: begin
          // IDLE and DONE accept a new request identically, so DONE overlaps the next start.
          state_d = IDLE;
          if (start) begin
            res_d = i_in_a;
            if (i_in_b != '0) begin
              rem_d      = i_in_b;
              dir_left_d = !i_funct3[2];
              rot_m_d    = i_rot;
              arith_m_d  = i_funct3[2] & i_op_alt & !i_rot;
              sign_d     = i_in_a[XLEN-1];
              state_d    = SHIFT;
            end else begin
              state_d = DONE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk_n) begin
    if (i_rst) begin
      state <= IDLE;
      res   <= '0;
      rem   <= '0;
    end else begin
      state <= state_d;
      res   <= res_d;
      rem   <= rem_d;
    end
  end

  always_ff @(posedge i_clk_n) begin
    dir_left <= dir_left_d;
    rot_m    <= rot_m_d;
    arith_m  <= arith_m_d;
    sign     <= sign_d;
  end

  assign o_result = res;
  assign o_busy   = (state == SHIFT);
  assign o_valid  = (state == DONE);

endmodule

// File: tb/tb_shifter_iter.sv
// Self-checking bench for shifter_iter: directed cases on a STEP=4 build, and random
// operations on STEP=4, STEP=1 and STEP=32 builds against an arithmetic reference model.
module tb_shifter_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_a [3];
  logic [4:0]  in_b [3];
  logic [2:0]  f3   [3];
  logic        alt  [3];
  logic        rot  [3];
  logic        en   [3];
  logic        kill [3];
  logic [31:0] res_o   [3];
  logic        busy_o  [3];
  logic        valid_o [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shifter_iter #(.XLEN(32), .STEP(4)) u_s4 (
    .i_clk_n(clk), .i_rst(rst), .i_in_a(in_a[0]), .i_in_b(in_b[0]), .i_funct3(f3[0]),
    .i_op_alt(alt[0]), .i_rot(rot[0]), .i_shift_en(en[0]), .i_kill(kill[0]),
    .o_result(res_o[0]), .o_busy(busy_o[0]), .o_valid(valid_o[0]));

  shifter_iter #(.XLEN(32), .STEP(1)) u_s1 (
    .i_clk_n(clk), .i_rst(rst), .i_in_a(in_a[1]), .i_in_b(in_b[1]), .i_funct3(f3[1]),
    .i_op_alt(alt[1]), .i_rot(rot[1]), .i_shift_en(en[1]), .i_kill(kill[1]),
    .o_result(res_o[1]), .o_busy(busy_o[1]), .o_valid(valid_o[1]));

  shifter_iter #(.XLEN(32), .STEP(32)) u_s32 (
    .i_clk_n(clk), .i_rst(rst), .i_in_a(in_a[2]), .i_in_b(in_b[2]), .i_funct3(f3[2]),
    .i_op_alt(alt[2]), .i_rot(rot[2]), .i_shift_en(en[2]), .i_kill(kill[2]),
    .o_result(res_o[2]), .o_busy(busy_o[2]), .o_valid(valid_o[2]));

  function automatic int step_of(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 1 : 32);
  endfunction

  // op: 0 sll, 1 srl, 2 sra, 3 rol, 4 ror
  function automatic logic [31:0] model(input logic [31:0] a, input int amt, input int op);
    logic signed [31:0] s;
    logic [63:0]        dbl;
    s   = a;
    dbl = {a, a};
    case (op)
      0:       return a << amt;
      1:       return a >> amt;
      2:       return s >>> amt;
      3:       begin dbl = dbl << amt; return dbl[63:32]; end
      default: begin dbl = dbl >> amt; return dbl[31:0]; end
    endcase
  endfunction

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int d, input logic [31:0] a, input int amt, input int op, input logic a_alt);
    in_a[d] = a;
    in_b[d] = amt[4:0];
    f3[d]   = (op == 0 || op == 3) ? 3'b001 : 3'b101;
    rot[d]  = (op >= 3);
    alt[d]  = (op == 2) ? 1'b1 : ((op == 1) ? 1'b0 : a_alt);
    en[d]   = 1'b1;
  endtask

  task automatic run_op(input int d, input logic [31:0] a, input int amt, input int op, input logic a_alt,
                        output logic [31:0] r, output int busy_n, output int lat);
    @(negedge clk);
    drive(d, a, amt, op, a_alt);
    @(posedge clk);
    #1 en[d] = 1'b0;
    busy_n = 0;
    lat    = -1;
    r      = '0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (valid_o[d]) begin
        lat = c;
        r   = res_o[d];
        break;
      end
      if (busy_o[d]) busy_n++;
    end
    chk_val("valid_seen", 64'(lat > 0), 64'd1);
  endtask

  task automatic op_check(input int d, input logic [31:0] a, input int amt, input int op, input logic a_alt);
    logic [31:0] r;
    int          bn, lat, exp_busy;
    exp_busy = (amt + step_of(d) - 1) / step_of(d);
    run_op(d, a, amt, op, a_alt, r, bn, lat);
    chk_val("result", 64'(r), 64'(model(a, amt, op)));
    chk_val("busy_cycles", 64'(bn), 64'(exp_busy));
    chk_val("latency", 64'(lat), 64'(exp_busy + 1));
  endtask

  initial begin
    logic [31:0] r;
    int          bn, lat;
    for (int d = 0; d < 3; d++) begin
      in_a[d] = '0; in_b[d] = '0; f3[d] = '0; alt[d] = 0; rot[d] = 0; en[d] = 0; kill[d] = 0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_val("rst_result", 64'(res_o[0]), 64'h0);
    chk_val("rst_busy", 64'(busy_o[0]), 64'h0);
    chk_val("rst_valid", 64'(valid_o[0]), 64'h0);

    // Directed shifts
    run_op(0, 32'h0000_0001, 31, 0, 1'b0, r, bn, lat);
    chk_val("sll31_res", 64'(r), 64'h8000_0000);
    chk_val("sll31_busy", 64'(bn), 64'd8);
    chk_val("sll31_lat", 64'(lat), 64'd9);
    @(negedge clk);
    chk_val("valid_one_pulse", 64'(valid_o[0]), 64'h0);

    run_op(0, 32'h8000_0000, 5, 2, 1'b1, r, bn, lat);
    chk_val("sra5_res", 64'(r), 64'hFC00_0000);
    chk_val("sra5_busy", 64'(bn), 64'd2);
    run_op(0, 32'h8000_0000, 5, 1, 1'b0, r, bn, lat);
    chk_val("srl5_res", 64'(r), 64'h0400_0000);
    run_op(0, 32'h1234_5678, 8, 4, 1'b1, r, bn, lat);
    chk_val("ror8_res", 64'(r), 64'h7812_3456);
    run_op(0, 32'h1234_5678, 4, 3, 1'b0, r, bn, lat);
    chk_val("rol4_res", 64'(r), 64'h2345_6781);

    // Zero amount, then back-to-back request issued in the DONE cycle
    @(negedge clk);
    drive(0, 32'hDEAD_BEEF, 0, 0, 1'b0);
    @(posedge clk);
    #1 drive(0, 32'h0000_0001, 4, 0, 1'b0);
    @(negedge clk);
    chk_val("amt0_valid", 64'(valid_o[0]), 64'h1);
    chk_val("amt0_busy", 64'(busy_o[0]), 64'h0);
    chk_val("amt0_res", 64'(res_o[0]), 64'hDEAD_BEEF);
    @(posedge clk);
    #1 en[0] = 1'b0;
    @(negedge clk);
    chk_val("b2b_busy", 64'(busy_o[0]), 64'h1);
    chk_val("b2b_valid", 64'(valid_o[0]), 64'h0);
    @(negedge clk);
    chk_val("b2b_done_valid", 64'(valid_o[0]), 64'h1);
    chk_val("b2b_done_res", 64'(res_o[0]), 64'h0000_0010);

    // Kill on the second busy cycle
    @(negedge clk);
    drive(0, 32'hFFFF_FFFF, 16, 0, 1'b0);
    @(posedge clk);
    #1 en[0] = 1'b0;
    @(negedge clk);
    chk_val("kill_busy1", 64'(busy_o[0]), 64'h1);
    @(negedge clk);
    chk_val("kill_busy2", 64'(busy_o[0]), 64'h1);
    kill[0] = 1'b1;
    @(posedge clk);
    #1 kill[0] = 1'b0;
    @(negedge clk);
    chk_val("kill_idle_busy", 64'(busy_o[0]), 64'h0);
    chk_val("kill_res_partial", 64'(res_o[0]), 64'hFFFF_FFF0);
    bn = 0;
    for (int c = 0; c < 8; c++) begin
      if (valid_o[0]) bn++;
      @(negedge clk);
    end
    chk_val("kill_no_valid", 64'(bn), 64'h0);

    // Kill and request together; then a non-shift funct3
    drive(0, 32'h0000_0001, 3, 0, 1'b0);
    kill[0] = 1'b1;
    @(posedge clk);
    #1 begin en[0] = 1'b0; kill[0] = 1'b0; end
    @(negedge clk);
    chk_val("killreq_busy", 64'(busy_o[0]), 64'h0);
    chk_val("killreq_valid", 64'(valid_o[0]), 64'h0);
    in_a[0] = 32'h0000_1234; in_b[0] = 5'd3; f3[0] = 3'b000; en[0] = 1'b1;
    @(posedge clk);
    #1 en[0] = 1'b0;
    @(negedge clk);
    chk_val("nonshift_busy", 64'(busy_o[0]), 64'h0);
    chk_val("nonshift_valid", 64'(valid_o[0]), 64'h0);
    chk_val("nonshift_res", 64'(res_o[0]), 64'hFFFF_FFF0);

    // Request held during SHIFT is ignored
    drive(0, 32'h8000_0000, 12, 1, 1'b0);
    @(posedge clk);
    #1 drive(0, 32'hFFFF_FFFF, 1, 0, 1'b0);
    bn = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (busy_o[0]) bn++;
    end
    en[0] = 1'b0;
    chk_val("held_busy", 64'(bn), 64'd3);
    @(negedge clk);
    chk_val("held_valid", 64'(valid_o[0]), 64'h1);
    chk_val("held_res", 64'(res_o[0]), 64'h0008_0000);

    // Reset mid-shift, then reset together with a request
    @(negedge clk);
    drive(0, 32'h0000_0001, 31, 0, 1'b0);
    @(posedge clk);
    #1 en[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_val("midrst_res", 64'(res_o[0]), 64'h0);
    chk_val("midrst_busy", 64'(busy_o[0]), 64'h0);
    chk_val("midrst_valid", 64'(valid_o[0]), 64'h0);
    rst = 1'b1;
    drive(0, 32'h0000_0005, 2, 0, 1'b0);
    @(posedge clk);
    #1 begin rst = 1'b0; en[0] = 1'b0; end
    @(negedge clk);
    chk_val("rstreq_busy", 64'(busy_o[0]), 64'h0);
    chk_val("rstreq_valid", 64'(valid_o[0]), 64'h0);
    chk_val("rstreq_res", 64'(res_o[0]), 64'h0);

    // Random operations on each build
    for (int d = 0; d < 3; d++) begin
      int n;
      n = (d == 0) ? 200 : 1000;
      for (int i = 0; i < n; i++) begin
        op_check(d, $urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 4)),
                 1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shifter_iter.md
# shifter_iter

Parametrised multi-bit-per-cycle iterative shifter for the integer execute stage. It is the successor to the single-bit serial shifter, generalised to any XLEN and to STEP bits per cycle, and it adds rotate operations, a kill input and an explicit result-valid pulse. It sits beside the ALU, is enabled by the decode shift-enable, and stalls the pipeline through `o_busy` while iterating. It trades area against latency when the barrel shifter is configured out.

## Interface
- `XLEN`, default 32: data width; power of two, 8 to 64.
- `STEP`, default 4: maximum bits shifted per cycle; power of two, 1 to XLEN.
- `SW`, derived as log2(XLEN): shift-amount width.
- `i_clk_n` in 1: inverted clock input; all state updates on its rising edge. This is the only clock.
- `i_rst` in 1: reset; synchronous, active-high.
- `i_in_a` in XLEN: operand to shift.
- `i_in_b` in SW: shift amount; wider source bits are already dropped by the caller.
- `i_funct3` in 3: `001` = left, `101` = right; any other value is not a shift.
- `i_op_alt` in 1: on a right shift, 1 = arithmetic and 0 = logical; ignored when `i_rot` = 1.
- `i_rot` in 1: 1 = rotate; left rotate is rol, right rotate is ror.
- `i_shift_en` in 1: operation request.
- `i_kill` in 1: abort the current operation (pipeline flush).
- `o_result` out XLEN: shift result register.
- `o_busy` out 1: high while iterating.
- `o_valid` out 1: one-cycle pulse when `o_result` holds a finished result.

## Operation
- Decoded request: `start` = `i_shift_en` && (funct3 == `001` || funct3 == `101`) && !`i_kill` && state != SHIFT.
- Internal state is `res`, `rem` (SW bits), direction, mode (logical, arithmetic or rotate) and the sign bit latched from `i_in_a[XLEN-1]`.
- IDLE:
  - On `start` with `i_in_b` != 0: load `res` = `i_in_a`, `rem` = `i_in_b`, latch direction, mode and sign, then go to SHIFT.
  - On `start` with `i_in_b` == 0: load `res` = `i_in_a` and go directly to DONE.
- SHIFT: each cycle shift `res` by k = min(STEP, `rem`) and set `rem` = `rem` − k.
  - Logical fill is 0.
  - Arithmetic fill is the latched sign.
  - Rotate wraps the bits that leave one end into the other end.
  - When `rem` reaches 0, go to DONE.
- DONE lasts one cycle, with `o_valid` = 1.
  - `start` in DONE is accepted and loads exactly as from IDLE, so back-to-back operations need no gap.
  - Otherwise return to IDLE.
- Outputs:
  - `o_result` = `res` at all times. It holds its value in IDLE until the next `start` loads it.
  - `o_busy` = (state == SHIFT).
  - `o_valid` = (state == DONE).
- Requests while SHIFT are ignored: no queueing, and no corruption of the operation in flight.
- Non-shift funct3 values, and `i_shift_en` = 0, never change state or `res`.
- Arithmetic rules:
  - The amount is taken modulo XLEN; SW-bit truncation already guarantees this.
  - k is never 0 in SHIFT.
  - A shift by k is equivalent to k serial 1-bit shifts.
- Kill:
  - `i_kill` = 1 in any state moves state to IDLE next cycle and clears `rem`.
  - `res` keeps its partial value.
  - `o_valid` is not asserted for the killed operation.
  - Kill and request in the same cycle: kill wins and nothing starts.
- Reset: `i_rst` = 1 at any time, including mid-shift, sets state IDLE, `res` = 0 and `rem` = 0 on the next edge.
  - Outputs after reset: `o_result` = 0, `o_busy` = 0, `o_valid` = 0.
  - Reset has priority over kill and start.

## Timing
- Latency: `start` edge, then ceil(amt/STEP) SHIFT cycles, then one DONE cycle.
  - `o_valid` rises ceil(amt/STEP)+1 edges after the start edge.
  - For amt = 0, `o_valid` rises on the edge after the start edge and `o_busy` never asserts.
- `o_busy` is high for exactly ceil(amt/STEP) cycles, from the edge after the start edge.
- Throughput: one operation per ceil(amt/STEP)+1 cycles; DONE overlaps the next start.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Critical path: one STEP-wide mux stage plus the `rem` subtract. STEP = XLEN degenerates to a single-cycle barrel shift plus DONE.

## Test plan
- XLEN = 32, STEP = 4, sll of 0x00000001 by 31 → `o_busy` high 8 cycles; `o_valid` pulses once with `o_result` = 0x80000000.
- sra of 0x80000000 by 5 → 2 busy cycles, then 0xFC000000. srl of the same operand by 5 → 0x04000000. ror of 0x12345678 by 8 → 0x78123456. rol of 0x12345678 by 4 → 0x23456781.
- Amount 0 on 0xDEADBEEF → `o_busy` never asserts; `o_valid` on the next cycle with `o_result` = 0xDEADBEEF. Issue a new request in the DONE cycle → accepted with no bubble.
- Request sll of 0xFFFFFFFF by 16, then raise `i_kill` on the 2nd busy cycle → IDLE next cycle, no `o_valid`. A request held during SHIFT is ignored and the original result is still correct.
- Assert `i_rst` mid-shift → next edge `o_result` = 0, `o_busy` = 0, `o_valid` = 0. `i_rst` together with a request → no start.
- STEP = 1 and STEP = 32 builds, 1000 random operand, amount and op triples each → results match the reference model and busy cycles equal ceil(amt/STEP).
